vram_port2_arbiter: RTL and testbench

- Shares the single read/write port (port 2) of the 8-bit-per-pixel video memory between two requesters:
  - the CPU memory-mapped pixel interface;
  - a hardware rectangle-fill engine used for screen clears and solid boxes.
- Port 1 stays dedicated to display scan-out and is not touched by this block.
- Sits between the CPU MMIO decode and the video memory; drives the port-2 address, data and enables directly.

---
 rtl/vram_port2_arbiter.sv | 149 ++++++++++++++
 tb/tb_vram_port2_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_port2_arbiter.sv
// rtl/vram_port2_arbiter.sv - video memory port 2 arbiter between CPU MMIO and rectangle-fill engine
module vram_port2_arbiter #(
    parameter int H_PIXELS = 80,
    parameter int V_PIXELS = 60,
    parameter int XW       = 7,
    parameter int YW       = 6,
    parameter int AW       = 13
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          CPU_REQ,
    input  logic          CPU_WE,
    input  logic [AW-1:0] CPU_ADDR,
    input  logic [7:0]    CPU_DIN,
    output logic          CPU_ACK,
    output logic [7:0]    CPU_DOUT,
    input  logic          FILL_START,
    input  logic [XW-1:0] FILL_X0,
    input  logic [XW-1:0] FILL_X1,
    input  logic [YW-1:0] FILL_Y0,
    input  logic [YW-1:0] FILL_Y1,
    input  logic [7:0]    FILL_COLOR,
    output logic          FILL_BUSY,
    output logic          FILL_DONE,
    output logic [AW-1:0] MEM_ADDR2,
    output logic [7:0]    MEM_DIN2,
    output logic          MEM_WE2,
    output logic          MEM_RDEN2,
    input  logic [7:0]    MEM_DOUT2
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_FILL = 1'b1;

    localparam logic [XW-1:0] X_LAST   = XW'(H_PIXELS - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(V_PIXELS - 1);
    localparam logic [AW-1:0] ROW_STEP = AW'(H_PIXELS);

    logic [0:0]    state;
    logic [XW-1:0] x;
    logic [XW-1:0] x0;
    logic [XW-1:0] x1;
    logic [YW-1:0] y;
    logic [YW-1:0] y1;
    logic [AW-1:0] row_base;
    logic [7:0]    color;

    logic          cpu_gnt;
    logic          fill_wr;
    logic [XW-1:0] clip_x1;
    logic [YW-1:0] clip_y1;
    logic          fill_empty;

    // A CPU access acknowledged this cycle was granted last cycle, so CPU_ACK doubles as the gap marker
    assign cpu_gnt  = CPU_REQ & ~CPU_ACK;
    assign fill_wr  = (state == S_FILL) & ~cpu_gnt;
    assign CPU_DOUT = MEM_DOUT2;

    assign clip_x1    = (FILL_X1 > X_LAST) ? X_LAST : FILL_X1;
    assign clip_y1    = (FILL_Y1 > Y_LAST) ? Y_LAST : FILL_Y1;
    assign fill_empty = (FILL_X0 > clip_x1) | (FILL_Y0 > clip_y1) |
                        (FILL_X0 > X_LAST)  | (FILL_Y0 > Y_LAST);

    // Port-2 drive follows the current grant; reset kills the enables immediately
    always_comb begin
        MEM_ADDR2 = '0;
        MEM_DIN2  = '0;
        MEM_WE2   = 1'b0;
        MEM_RDEN2 = 1'b0;
        if (!RST) begin
            if (cpu_gnt) begin
                MEM_ADDR2 = CPU_ADDR;
                if (CPU_WE) begin
                    MEM_WE2  = 1'b1;
                    MEM_DIN2 = CPU_DIN;
                end else begin
                    MEM_RDEN2 = 1'b1;
                end
            end else if (state == S_FILL) begin
                MEM_WE2   = 1'b1;
                MEM_ADDR2 = row_base + AW'(x);
                MEM_DIN2  = color;
            end
        end
    end

    // CPU completion pulse, one cycle after its grant
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            CPU_ACK <= 1'b0;
        end else begin
            CPU_ACK <= cpu_gnt;
        end
    end

    // Fill engine: latch the clipped rectangle, then scan row-major on every cycle the CPU leaves free
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= S_IDLE;
            FILL_BUSY <= 1'b0;
            FILL_DONE <= 1'b0;
            x         <= '0;
            x0        <= '0;
            x1        <= '0;
            y         <= '0;
            y1        <= '0;
            row_base  <= '0;
            color     <= '0;
        end else begin
            FILL_DONE <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (FILL_START) begin
                        if (fill_empty) begin
                            FILL_DONE <= 1'b1;
                        end else begin
                            x0        <= FILL_X0;
                            x         <= FILL_X0;
                            x1        <= clip_x1;
                            y         <= FILL_Y0;
                            y1        <= clip_y1;
                            row_base  <= AW'(FILL_Y0) * ROW_STEP;
                            color     <= FILL_COLOR;
                            state     <= S_FILL;
                            FILL_BUSY <= 1'b1;
                        end
                    end
                end
                S_FILL: begin
                    if (fill_wr) begin
                        if (x < x1) begin
                            x <= x + XW'(1);
                        end else if (y == y1) begin
                            state     <= S_IDLE;
                            FILL_BUSY <= 1'b0;
                            FILL_DONE <= 1'b1;
                        end else begin
                            x        <= x0;
                            row_base <= row_base + ROW_STEP;
                            y        <= y + YW'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vram_port2_arbiter.sv
// tb/tb_vram_port2_arbiter.sv - randomized self-checking bench for vram_port2_arbiter
module tb_vram_port2_arbiter;

    localparam int H  = 80;
    localparam int V  = 60;
    localparam int XW = 7;
    localparam int YW = 6;
    localparam int AW = 13;

    logic          CLK = 1'b0;
    logic          RST;
    logic          CPU_REQ, CPU_WE;
    logic [AW-1:0] CPU_ADDR;
    logic [7:0]    CPU_DIN;
    logic          CPU_ACK;
    logic [7:0]    CPU_DOUT;
    logic          FILL_START;
    logic [XW-1:0] FILL_X0, FILL_X1;
    logic [YW-1:0] FILL_Y0, FILL_Y1;
    logic [7:0]    FILL_COLOR;
    logic          FILL_BUSY, FILL_DONE;
    logic [AW-1:0] MEM_ADDR2;
    logic [7:0]    MEM_DIN2;
    logic          MEM_WE2, MEM_RDEN2;
    logic [7:0]    MEM_DOUT2;

    vram_port2_arbiter #(.H_PIXELS(H), .V_PIXELS(V), .XW(XW), .YW(YW), .AW(AW)) dut (
        .CLK(CLK), .RST(RST),
        .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_ADDR(CPU_ADDR), .CPU_DIN(CPU_DIN),
        .CPU_ACK(CPU_ACK), .CPU_DOUT(CPU_DOUT),
        .FILL_START(FILL_START), .FILL_X0(FILL_X0), .FILL_X1(FILL_X1),
        .FILL_Y0(FILL_Y0), .FILL_Y1(FILL_Y1), .FILL_COLOR(FILL_COLOR),
        .FILL_BUSY(FILL_BUSY), .FILL_DONE(FILL_DONE),
        .MEM_ADDR2(MEM_ADDR2), .MEM_DIN2(MEM_DIN2), .MEM_WE2(MEM_WE2),
        .MEM_RDEN2(MEM_RDEN2), .MEM_DOUT2(MEM_DOUT2)
    );

    always #5 CLK = ~CLK;

    // video memory port 2 with synchronous read
    logic [7:0] vmem [0:8191];
    always @(posedge CLK) begin
        if (MEM_WE2) vmem[MEM_ADDR2] <= MEM_DIN2;
        if (MEM_RDEN2) MEM_DOUT2 <= vmem[MEM_ADDR2];
    end

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference model
    logic [7:0] ref_mem [0:8191];
    int   fq[$];
    int   m_color;
    bit   m_busy = 0, m_done = 0, m_prev_gnt = 0, m_prev_we = 0;
    int   m_rd_exp = 0;
    int   fill_cnt = 0, done_cnt = 0, busy_cyc = 0, grant_cnt = 0;
    int   req_cnt = 0, ack_cnt = 0;
    int   last_fill_addr = -1;
    bit   g, fw;

    function automatic void plan_fill(input int x0, input int x1, input int y0, input int y1, input int c);
        int cx1, cy1;
        cx1 = (x1 > H - 1) ? H - 1 : x1;
        cy1 = (y1 > V - 1) ? V - 1 : y1;
        fq.delete();
        for (int yy = y0; yy <= cy1; yy++)
            for (int xx = x0; xx <= cx1; xx++)
                fq.push_back(yy * H + xx);
        m_color = c;
    endfunction

    // per-cycle scoreboard, sampled mid-cycle
    always @(negedge CLK) begin
        if (!RST) begin
            g = CPU_REQ && !m_prev_gnt;
            check_eq("cpu_ack", CPU_ACK, m_prev_gnt);
            if (m_prev_gnt && !m_prev_we) check_eq("cpu_dout", CPU_DOUT, m_rd_exp);
            check_eq("fill_busy", FILL_BUSY, m_busy);
            check_eq("fill_done", FILL_DONE, m_done);
            if (FILL_DONE) done_cnt++;
            if (FILL_BUSY) busy_cyc++;
            fw = 0;
            if (g) begin
                grant_cnt++;
                check_eq("cpu_addr2", MEM_ADDR2, CPU_ADDR);
                check_eq("cpu_we2", MEM_WE2, CPU_WE);
                check_eq("cpu_rden2", MEM_RDEN2, !CPU_WE);
                if (CPU_WE) begin
                    check_eq("cpu_din2", MEM_DIN2, CPU_DIN);
                    ref_mem[CPU_ADDR] = CPU_DIN;
                end else begin
                    m_rd_exp = ref_mem[CPU_ADDR];
                end
                m_prev_we = CPU_WE;
            end else if (m_busy && fq.size() > 0) begin
                check_eq("fill_we2", MEM_WE2, 1);
                check_eq("fill_rden2", MEM_RDEN2, 0);
                check_eq("fill_addr2", MEM_ADDR2, fq[0]);
                check_eq("fill_din2", MEM_DIN2, m_color);
                ref_mem[fq[0]] = 8'(m_color);
                last_fill_addr = MEM_ADDR2;
                void'(fq.pop_front());
                fw = 1;
                fill_cnt++;
            end else begin
                check_eq("idle_we2", MEM_WE2, 0);
                check_eq("idle_rden2", MEM_RDEN2, 0);
                check_eq("idle_addr2", MEM_ADDR2, 0);
                check_eq("idle_din2", MEM_DIN2, 0);
            end
            if (m_busy) begin
                m_done = 0;
                if (fw && fq.size() == 0) begin
                    m_busy = 0;
                    m_done = 1;
                end
            end else begin
                m_done = 0;
                if (FILL_START) begin
                    plan_fill(int'(FILL_X0), int'(FILL_X1), int'(FILL_Y0), int'(FILL_Y1), int'(FILL_COLOR));
                    if (fq.size() == 0) m_done = 1;
                    else m_busy = 1;
                end
            end
            m_prev_gnt = g;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic cpu_access(input logic we, input logic [AW-1:0] addr, input logic [7:0] din,
                              input bit drop, output logic [7:0] rd);
        int n;
        CPU_REQ = 1; CPU_WE = we; CPU_ADDR = addr; CPU_DIN = din;
        req_cnt++;
        n = 0;
        do begin
            cyc(1);
            n++;
        end while (!CPU_ACK && n < 8);
        check_eq("cpu_ack_seen", CPU_ACK, 1);
        if (CPU_ACK) ack_cnt++;
        rd = CPU_DOUT;
        if (drop) CPU_REQ = 0;
    endtask

    task automatic start_fill(input int x0, input int x1, input int y0, input int y1, input int c);
        FILL_X0 = XW'(x0); FILL_X1 = XW'(x1);
        FILL_Y0 = YW'(y0); FILL_Y1 = YW'(y1);
        FILL_COLOR = 8'(c);
        FILL_START = 1;
        cyc(1);
        FILL_START = 0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((m_busy || m_done) && n < 6000) begin
            cyc(1);
            n++;
        end
        check_eq("fill_idle", FILL_BUSY, 0);
    endtask

    int f0, d0, b0, r0, a0, gr0, bad;
    logic [7:0] rd;
    bit stop_cpu;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8192; i++) ref_mem[i] = 8'h00;
        RST = 1; CPU_REQ = 0; CPU_WE = 0; CPU_ADDR = '0; CPU_DIN = '0;
        FILL_START = 0; FILL_X0 = '0; FILL_X1 = '0; FILL_Y0 = '0; FILL_Y1 = '0; FILL_COLOR = '0;
        cyc(3);
        check_eq("rst_ack", CPU_ACK, 0);
        check_eq("rst_busy", FILL_BUSY, 0);
        check_eq("rst_done", FILL_DONE, 0);
        check_eq("rst_we2", MEM_WE2, 0);
        check_eq("rst_rden2", MEM_RDEN2, 0);
        RST = 0;
        cyc(2);

        // full clear, clipped to the framebuffer
        f0 = fill_cnt; d0 = done_cnt;
        start_fill(0, 127, 0, 63, 8'h00);
        wait_idle();
        cyc(1);
        check_eq("clear_count", fill_cnt - f0, 4800);
        check_eq("clear_last", last_fill_addr, 4799);
        check_eq("clear_done", done_cnt - d0, 1);

        // CPU write then read back
        cpu_access(1, 13'd100, 8'h3C, 1, rd);
        cyc(2);
        cpu_access(0, 13'd100, 8'h00, 1, rd);
        check_eq("rd100", rd, 8'h3C);
        cyc(2);

        // small rectangle
        f0 = fill_cnt; d0 = done_cnt; b0 = busy_cyc;
        start_fill(2, 4, 1, 2, 8'hE0);
        wait_idle();
        cyc(1);
        check_eq("rect_count", fill_cnt - f0, 6);
        check_eq("rect_busy_cycles", busy_cyc - b0, 6);
        check_eq("rect_done", done_cnt - d0, 1);
        check_eq("rect_last", last_fill_addr, 164);

        // CPU held continuously during a fill
        f0 = fill_cnt; r0 = req_cnt; a0 = ack_cnt; gr0 = grant_cnt;
        stop_cpu = 0;
        fork
            begin
                start_fill(2, 4, 1, 2, 8'h7B);
                wait_idle();
                stop_cpu = 1;
            end
            begin
                while (!stop_cpu)
                    cpu_access(1'($urandom), 13'($urandom_range(0, 4799)), 8'($urandom), 0, rd);
                CPU_REQ = 0;
            end
        join
        cyc(2);
        check_eq("held_fill_count", fill_cnt - f0, 6);
        check_eq("held_acks", ack_cnt - a0, req_cnt - r0);
        check_eq("held_grants", grant_cnt - gr0, req_cnt - r0);

        // empty rectangle, then start while busy
        f0 = fill_cnt; d0 = done_cnt; b0 = busy_cyc;
        start_fill(10, 5, 0, 3, 8'h99);
        cyc(3);
        check_eq("empty_writes", fill_cnt - f0, 0);
        check_eq("empty_done", done_cnt - d0, 1);
        check_eq("empty_busy", busy_cyc - b0, 0);
        f0 = fill_cnt;
        start_fill(2, 4, 1, 2, 8'h11);
        start_fill(0, 3, 0, 0, 8'h22);
        wait_idle();
        check_eq("busy_start_ignored", fill_cnt - f0, 6);

        // reset in the middle of a fill
        cyc(2);
        f0 = fill_cnt; d0 = done_cnt;
        start_fill(2, 4, 1, 2, 8'hC3);
        cyc(3);
        check_eq("pre_rst_writes", fill_cnt - f0, 3);
        #1 RST = 1;
        #1;
        check_eq("rst_async_we2", MEM_WE2, 0);
        check_eq("rst_async_busy", FILL_BUSY, 0);
        repeat (3) begin
            @(negedge CLK);
            check_eq("rst_no_done", FILL_DONE, 0);
        end
        @(posedge CLK);
        #1;
        RST = 0;
        m_busy = 0; m_done = 0; m_prev_gnt = 0; fq.delete();
        check_eq("rst_done_none", done_cnt - d0, 0);
        cyc(1);
        f0 = fill_cnt; d0 = done_cnt;
        start_fill(2, 4, 1, 2, 8'h5A);
        wait_idle();
        cyc(1);
        check_eq("post_rst_count", fill_cnt - f0, 6);
        check_eq("post_rst_done", done_cnt - d0, 1);

        // randomized mix of fills and CPU traffic
        stop_cpu = 0;
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    int x0, y0;
                    x0 = $urandom_range(1, 85);
                    y0 = $urandom_range(1, 62);
                    start_fill(x0, x0 + $urandom_range(0, 5) - 1, y0, y0 + $urandom_range(0, 3) - 1, $urandom);
                    if ($urandom_range(0, 1) == 1)
                        start_fill($urandom_range(0, 20), $urandom_range(0, 79), 0, 2, $urandom);
                    wait_idle();
                    cyc($urandom_range(0, 3));
                end
                stop_cpu = 1;
            end
            begin
                while (!stop_cpu) begin
                    if ($urandom_range(0, 2) == 0) begin
                        CPU_REQ = 0;
                        cyc($urandom_range(1, 3));
                    end
                    cpu_access(1'($urandom), 13'($urandom_range(0, 4799)), 8'($urandom),
                               1'($urandom), rd);
                end
                CPU_REQ = 0;
            end
        join
        cyc(3);

        bad = 0;
        for (int i = 0; i < H * V; i++)
            if (vmem[i] !== ref_mem[i]) bad++;
        check_eq("mem_image", bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
